// File: rtl/nonce_pkg.sv
// Shared constants and FSM state type for the nonce transmit queue.
// Latency: none (declarations only). Backpressure: n/a.
// Imported by the interface, FIFO and top.
package nonce_pkg;
    localparam int NONCE_W     = 32;
    localparam int ACK_TIMEOUT = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_ACK,
        ST_DRAIN
    } tx_state_e;
endpackage

// File: rtl/nonce_tx_queue_if.sv
// Hasher-side nonce strobes and UART-side transmit handshake as one bundle.
// Latency: wires only. Backpressure: carried by serial_busy.
// The queue uses the slave modport, the driver of the cores/UART uses master.
interface nonce_tx_queue_if
    import nonce_pkg::*;
#(
    parameter int SLAVES = 2
);
    logic [SLAVES-1:0]         new_nonces;
    logic [NONCE_W*SLAVES-1:0] slave_nonces;
    logic                      serial_busy;
    logic                      serial_send;
    logic [NONCE_W-1:0]        golden_nonce;

    modport slave (
        input  new_nonces, slave_nonces, serial_busy,
        output serial_send, golden_nonce
    );
    modport master (
        output new_nonces, slave_nonces, serial_busy,
        input  serial_send, golden_nonce
    );
endinterface

// File: rtl/nonce_fifo.sv
// Power-of-two FIFO with extra-bit pointers so full and empty never alias.
// Latency: 1 cycle push to head visible. Backpressure: push dropped when full unless popping.
// A pop on an empty FIFO is ignored.
module nonce_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok, pop_ok;

    assign count   = wr_q - rd_q;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign pop_dat = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= push_dat;
    end
endmodule

// File: rtl/nonce_tx_queue.sv
// Captures hasher nonces into per-slave slots, round-robins them into a FIFO, and sends them to a UART.
// Latency: strobe to FIFO 2 cycles, FIFO to serial_send 2 cycles. Backpressure: slots hold while FIFO full; overwrites count as drops.
// A lost UART request (no busy within ACK_TIMEOUT cycles) is also counted as a drop.
module nonce_tx_queue
    import nonce_pkg::*;
#(
    parameter int SLAVES = 2,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    nonce_tx_queue_if.slave        bus,
    output logic [$clog2(DEPTH):0] pending,
    output logic [7:0]             dropped
);
    localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam int TW = $clog2(ACK_TIMEOUT);

    logic [SLAVES-1:0]  slot_vld_q, slot_vld_d;
    logic [NONCE_W-1:0] slot_dat_q [SLAVES];
    logic [NONCE_W-1:0] slot_dat_d [SLAVES];
    logic [SW-1:0]      rr_q, rr_d;
    logic [SW-1:0]      push_idx;
    logic               push_req, push_en;
    logic [2:0]         slot_drops;

    tx_state_e          state_q, state_d;
    logic [TW-1:0]      tmr_q, tmr_d;
    logic [NONCE_W-1:0] golden_q, golden_d;
    logic               pop, ack_drop;
    logic [7:0]         dropped_q, dropped_d;
    logic [8:0]         drop_sum;

    logic               fifo_full, fifo_empty;
    logic [NONCE_W-1:0] fifo_dat;

    // Search starts at rr_q, which points one past the last pushed slave.
    always_comb begin
        push_req = 1'b0;
        push_idx = '0;
        for (int k = 0; k < SLAVES; k++) begin
            if (!push_req && slot_vld_q[(int'(rr_q) + k) % SLAVES]) begin
                push_req = 1'b1;
                push_idx = SW'((int'(rr_q) + k) % SLAVES);
            end
        end
    end

    assign push_en = push_req && !fifo_full;

    always_comb begin
        slot_vld_d = slot_vld_q;
        slot_dat_d = slot_dat_q;
        slot_drops = '0;
        rr_d       = rr_q;
        if (push_en) rr_d = (push_idx == SW'(SLAVES - 1)) ? '0 : push_idx + 1'b1;
        for (int i = 0; i < SLAVES; i++) begin
            if (bus.new_nonces[i]) begin
                slot_vld_d[i] = 1'b1;
                slot_dat_d[i] = bus.slave_nonces[NONCE_W*i +: NONCE_W];
                // A slot drained in this same cycle hands its old value to the FIFO, so nothing is lost.
                if (slot_vld_q[i] && !(push_en && push_idx == SW'(i)))
                    slot_drops = slot_drops + 3'd1;
            end else if (push_en && push_idx == SW'(i)) begin
                slot_vld_d[i] = 1'b0;
            end
        end
    end

    nonce_fifo #(.WIDTH(NONCE_W), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push_en),
        .push_dat (slot_dat_q[push_idx]),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (pending)
    );

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        golden_d = golden_q;
        pop      = 1'b0;
        ack_drop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !bus.serial_busy) begin
                    pop      = 1'b1;
                    golden_d = fifo_dat;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                tmr_d   = '0;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                if (bus.serial_busy) begin
                    state_d = ST_DRAIN;
                end else if (tmr_q == TW'(ACK_TIMEOUT - 1)) begin
                    state_d  = ST_IDLE;
                    ack_drop = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!bus.serial_busy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign drop_sum  = {1'b0, dropped_q} + 9'(slot_drops) + 9'(ack_drop);
    assign dropped_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_vld_q <= '0;
            for (int i = 0; i < SLAVES; i++) slot_dat_q[i] <= '0;
            rr_q      <= '0;
            state_q   <= ST_IDLE;
            tmr_q     <= '0;
            golden_q  <= '0;
            dropped_q <= '0;
        end else begin
            slot_vld_q <= slot_vld_d;
            slot_dat_q <= slot_dat_d;
            rr_q       <= rr_d;
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            golden_q   <= golden_d;
            dropped_q  <= dropped_d;
        end
    end

    assign bus.serial_send  = (state_q == ST_SEND);
    assign bus.golden_nonce = golden_q;
    assign dropped          = dropped_q;
endmodule

// File: tb/tb_nonce_tx_queue.sv
// Directed bench for nonce_tx_queue: vector table for simple strobe patterns plus hand-written corner sequences.
module tb_nonce_tx_queue;
    import nonce_pkg::*;

    logic       clk;
    logic       reset;
    logic [2:0] pending;
    logic [7:0] dropped;

    nonce_tx_queue_if #(.SLAVES(2)) ifc ();

    nonce_tx_queue #(.SLAVES(2), .DEPTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (ifc),
        .pending (pending),
        .dropped (dropped)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          uart_cnt = 0;
    logic        uart_en;
    logic        force_busy;
    logic [31:0] sent_q[$];
    int          sent_cyc[$];

    assign ifc.serial_busy = force_busy || (uart_cnt != 0);

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // UART model: records each request and answers with 40 cycles of busy.
    initial forever begin
        @(negedge clk);
        if (ifc.serial_send === 1'b1) begin
            sent_q.push_back(ifc.golden_nonce);
            sent_cyc.push_back(cyc);
            if (uart_en) uart_cnt = 40;
        end else if (uart_cnt > 0) begin
            uart_cnt--;
        end
    end

    typedef struct {
        logic        do_reset;
        logic [1:0]  mask;
        logic [31:0] n0;
        logic [31:0] n1;
        int          exp_n;
        logic [31:0] exp_w0;
        logic [31:0] exp_w1;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sent_at(input int i);
        if (i < sent_q.size()) return sent_q[i];
        return 32'hxxxxxxxx;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic strobe(input logic [1:0] mask, input logic [31:0] n0, input logic [31:0] n1);
        ifc.new_nonces   = mask;
        ifc.slave_nonces = {n1, n0};
        tick();
        ifc.new_nonces   = '0;
    endtask

    task automatic wait_sends(input int n, input int budget);
        int t;
        t = 0;
        while (sent_q.size() < n && t < budget) begin
            tick();
            t++;
        end
        chk("wait_send", 32'(sent_q.size() >= n), 32'd1);
    endtask

    logic [31:0] exp6 [5];

    initial begin
        reset            = 1'b1;
        uart_en          = 1'b1;
        force_busy       = 1'b0;
        ifc.new_nonces   = '0;
        ifc.slave_nonces = '0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_send",    32'(ifc.serial_send), 32'd0);
        chk("rst_golden",  ifc.golden_nonce,     32'd0);
        chk("rst_pending", 32'(pending),         32'd0);
        chk("rst_dropped", 32'(dropped),         32'd0);

        // Vector 1 follows vector 0 without reset: round-robin resumes at slave 1.
        vecs[0] = '{1'b1, 2'b01, 32'h1234ABCD, 32'h0,        1, 32'h1234ABCD, 32'h0};
        vecs[1] = '{1'b0, 2'b11, 32'h11110000, 32'h22220000, 2, 32'h22220000, 32'h11110000};
        vecs[2] = '{1'b1, 2'b11, 32'hAAAA0001, 32'hBBBB0002, 2, 32'hAAAA0001, 32'hBBBB0002};
        vecs[3] = '{1'b1, 2'b10, 32'h0,        32'hDEADBEEF, 1, 32'hDEADBEEF, 32'h0};

        for (int v = 0; v < 4; v++) begin
            if (vecs[v].do_reset) do_reset();
            sent_q.delete();
            strobe(vecs[v].mask, vecs[v].n0, vecs[v].n1);
            repeat (120) tick();
            chk($sformatf("v%0d_count", v), 32'(sent_q.size()), 32'(vecs[v].exp_n));
            chk($sformatf("v%0d_w0", v), sent_at(0), vecs[v].exp_w0);
            if (vecs[v].exp_n > 1) chk($sformatf("v%0d_w1", v), sent_at(1), vecs[v].exp_w1);
            chk($sformatf("v%0d_pending", v), 32'(pending), 32'd0);
            chk($sformatf("v%0d_dropped", v), 32'(dropped), 32'd0);
        end

        // FIFO full with UART held busy: 5th waits in the slot, 6th overwrites it.
        do_reset();
        sent_q.delete();
        force_busy = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            strobe(2'b01, 32'hC0000000 + 32'(k), 32'h0);
            tick();
            tick();
        end
        chk("full_pending", 32'(pending), 32'd4);
        chk("full_dropped", 32'(dropped), 32'd1);
        chk("full_nosend",  32'(sent_q.size()), 32'd0);
        force_busy = 1'b0;
        exp6 = '{32'hC0000001, 32'hC0000002, 32'hC0000003, 32'hC0000004, 32'hC0000006};
        repeat (320) tick();
        chk("full_count", 32'(sent_q.size()), 32'd5);
        for (int k = 0; k < 5; k++) chk($sformatf("full_w%0d", k), sent_at(k), exp6[k]);
        chk("full_pending_end", 32'(pending), 32'd0);
        chk("full_dropped_end", 32'(dropped), 32'd1);

        // Lost request: first word times out after 8 ACK cycles, second is acknowledged.
        do_reset();
        sent_q.delete();
        sent_cyc.delete();
        uart_en = 1'b0;
        strobe(2'b11, 32'h55550001, 32'h66660002);
        wait_sends(1, 50);
        uart_en = 1'b1;
        repeat (120) tick();
        chk("to_count",   32'(sent_q.size()), 32'd2);
        chk("to_w0",      sent_at(0), 32'h55550001);
        chk("to_w1",      sent_at(1), 32'h66660002);
        chk("to_dropped", 32'(dropped), 32'd1);
        if (sent_cyc.size() >= 2) chk("to_gap", 32'(sent_cyc[1] - sent_cyc[0]), 32'd10);

        // Reset during DRAIN with two words queued; a strobe in the reset cycle is ignored.
        do_reset();
        sent_q.delete();
        strobe(2'b11, 32'h70000001, 32'h70000002);
        tick();
        strobe(2'b01, 32'h70000003, 32'h0);
        repeat (12) tick();
        chk("drn_sent",    32'(sent_q.size()), 32'd1);
        chk("drn_pending", 32'(pending), 32'd2);
        reset            = 1'b1;
        ifc.new_nonces   = 2'b01;
        ifc.slave_nonces = {32'h0, 32'h7FFFFFFF};
        tick();
        reset          = 1'b0;
        ifc.new_nonces = '0;
        chk("drn_rst_send",    32'(ifc.serial_send), 32'd0);
        chk("drn_rst_pending", 32'(pending), 32'd0);
        repeat (150) tick();
        chk("drn_after_sent",    32'(sent_q.size()), 32'd1);
        chk("drn_after_pending", 32'(pending), 32'd0);
        chk("drn_after_dropped", 32'(dropped), 32'd0);

        // Continuous strobes into a full queue: counts then saturation.
        do_reset();
        force_busy     = 1'b1;
        ifc.new_nonces = 2'b01;
        for (int k = 0; k < 20; k++) begin
            ifc.slave_nonces = {32'h0, 32'(k)};
            tick();
        end
        ifc.new_nonces = '0;
        chk("sat_dropped15", 32'(dropped), 32'd15);
        chk("sat_pending",   32'(pending), 32'd4);
        ifc.new_nonces = 2'b01;
        repeat (300) tick();
        ifc.new_nonces = '0;
        tick();
        chk("sat_dropped255", 32'(dropped), 32'd255);

        // Both slaves every cycle: one drop per cycle while filling, two per cycle once full.
        do_reset();
        ifc.new_nonces = 2'b11;
        for (int k = 0; k < 10; k++) begin
            ifc.slave_nonces = {32'(k) + 32'h100, 32'(k)};
            tick();
        end
        ifc.new_nonces = '0;
        tick();
        chk("dual_dropped", 32'(dropped), 32'd14);
        force_busy = 1'b0;
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/nonce_tx_queue.md
NONCE_TX_QUEUE -- requirements
Module: nonce_tx_queue

Interface
REQ-001 Parameter SLAVES, default 2: number of hasher cores feeding the queue (1..4).
REQ-002 Parameter DEPTH, default 4: FIFO entries, power of two, 2..16.
REQ-003 clk  in  1  single clock, the comm clock domain; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 new_nonces  in  SLAVES  one-cycle strobe per slave, already synchronised to clk.
REQ-006 slave_nonces  in  32*SLAVES  slave i nonce on bits [32i+31:32i]; valid in the strobe cycle.
REQ-007 serial_busy  in  1  UART transmitter busy.
REQ-008 serial_send  out  1  one-cycle transmit request.
REQ-009 golden_nonce  out  32  word to transmit; stable from the serial_send cycle until serial_busy falls.
REQ-010 pending  out  clog2(DEPTH)+1  current FIFO occupancy.
REQ-011 dropped  out  8  saturating count of lost nonces.

Function
REQ-012 Each slave SHALL have a capture slot (valid flag + 32-bit nonce), loaded on its strobe.
REQ-013 On a strobe into an already-valid slot, the slot SHALL take the new nonce and dropped SHALL increment.
REQ-014 Per cycle, at most one valid slot SHALL be pushed, chosen round-robin starting after the last pushed slave.
REQ-015 A push SHALL occur only when the FIFO is not full; when full, slots SHALL hold their contents.
REQ-016 A strobe and a push of the same slot in the same cycle: the pushed value SHALL be the old nonce, the slot SHALL stay valid with the new nonce, and dropped SHALL NOT increment.
REQ-017 Strobe-to-FIFO latency SHALL be 2 cycles when the FIFO is uncontended: slot load, then push.
REQ-018 The FIFO SHALL support a simultaneous push and pop, including when full (occupancy unchanged) and when empty (the pop is not permitted).
REQ-019 The transmit FSM SHALL have states IDLE, SEND, ACK, DRAIN.
REQ-020 IDLE->SEND when the FIFO is non-empty and serial_busy=0: pop the head into golden_nonce.
REQ-021 In SEND, serial_send=1 for exactly one cycle, then go to ACK.
REQ-022 ACK->DRAIN on serial_busy=1; ACK->IDLE if serial_busy stays 0 for 8 cycles (lost request), incrementing dropped.
REQ-023 DRAIN->IDLE on serial_busy=0.
REQ-024 golden_nonce SHALL change only on a pop.
REQ-025 Back-to-back words SHALL be separated by at least one IDLE cycle.
REQ-026 dropped SHALL saturate at 255; when two drop events occur in one cycle it SHALL add 2, clamped to 255.
REQ-027 Pointers SHALL wrap modulo DEPTH; occupancy SHALL be computed with one extra bit, with no aliasing between full and empty.

Reset
REQ-028 Reset SHALL clear all slots, pointers, pending, dropped and the round-robin pointer (slave 0 first), and SHALL set the FSM to IDLE, serial_send=0 and golden_nonce=0.
REQ-029 Reset mid-transmit SHALL abandon the word, and serial_send SHALL be 0 in the cycle after reset is asserted.
REQ-030 Strobes coinciding with reset SHALL be ignored.

Structure
REQ-031 Shared package nonce_pkg SHALL hold NONCE_W=32, the FSM state enum, and ACK_TIMEOUT=8.
REQ-032 The FIFO SHALL be one sub-module, nonce_fifo (parameters WIDTH, DEPTH; outputs full, empty, count).
REQ-033 The arbiter and capture slots SHALL stay in the top module.

Verification
REQ-034 Single strobe, slave0=32'h1234ABCD, UART responds busy 1 cycle after send for 40 cycles -> serial_send exactly once, golden_nonce=32'h1234ABCD, pending 0 afterwards.
REQ-035 Both slaves strobe in the same cycle (32'hAAAA0001, 32'hBBBB0002) -> two words sent in order AAAA0001 then BBBB0002, dropped=0.
REQ-036 Slave0 strobes 6 times with serial_busy held high, DEPTH=4 -> pending=4, slot holds the 5th; the 6th overwrites the slot and dropped=1; after release, words 1-4 then 6 are sent.
REQ-037 serial_busy never asserts after send -> return to IDLE after 8 ACK cycles, dropped=1, next word sent.
REQ-038 Reset asserted during DRAIN with 2 words queued -> pending=0, serial_send=0, no further sends without new strobes.
REQ-039 300 single drops forced -> dropped stays at 255.
